// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
// Memory-side responder for the CPU memory port. A word-organised RAM of
// 2**ADDR_BITS 32-bit words that answers each request after a fixed,
// programmable number of wait cycles. It also raises a sticky flag when the
// requester breaks the handshake.
//
// Parameters
//   ADDR_BITS  word-index width (array depth = 2**ADDR_BITS words)
//   LATENCY    wait cycles between accept and mem_resp (0..15)
//
// Ports
//   clk              in   1   clock, rising edge
//   rst              in   1   synchronous active-high reset
//   mem_read         in   1   read request, held until mem_resp
//   mem_write        in   1   write request, held until mem_resp
//   mem_byte_enable  in   4   write lanes, bit i -> wdata[8i+7:8i]
//   mem_address      in   32  byte address, word index = [ADDR_BITS+1:2]
//   mem_wdata        in   32  write data
//   mem_resp         out  1   one-cycle completion pulse
//   mem_rdata        out  32  read data, valid in the mem_resp cycle
//   proto_err        out  1   sticky protocol-violation flag
// ---------------------------------------------------------------------------
module mem_responder #(
   parameter int ADDR_BITS = 8,
   parameter int LATENCY   = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [3:0]  mem_byte_enable,
   input  logic [31:0] mem_address,
   input  logic [31:0] mem_wdata,
   output logic        mem_resp,
   output logic [31:0] mem_rdata,
   output logic        proto_err
);

   localparam int DEPTH = 2 ** ADDR_BITS;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [3:0]           r_cnt;
   logic [3:0]           w_cnt_nxt;

   logic [31:0]          r_mem [DEPTH];

   // Request as captured in the accept cycle
   logic [ADDR_BITS-1:0] r_idx;
   logic [31:0]          r_addr;
   logic [31:0]          r_wdata;
   logic [3:0]           r_be;
   logic [1:0]           r_op;      // raw {read, write} seen at accept
   logic                 r_is_wr;   // a pure write; read+write is served as a read

   logic                 r_resp;
   logic [31:0]          r_rdata;
   logic                 r_err;

   logic                 w_req;
   logic                 w_accept;
   logic                 w_viol;
   logic                 w_is_wr_nxt;
   logic [ADDR_BITS-1:0] w_req_idx;
   logic [ADDR_BITS-1:0] w_rd_idx;

   assign w_req     = mem_read | mem_write;
   assign w_accept  = (r_state == S_IDLE) && w_req;
   assign w_req_idx = mem_address[ADDR_BITS+1:2];

   // With LATENCY==0 the response is entered straight from IDLE, so the read
   // index and op must come from the live request rather than the latches.
   assign w_rd_idx    = (r_state == S_IDLE) ? w_req_idx : r_idx;
   assign w_is_wr_nxt = (r_state == S_IDLE) ? (mem_write & ~mem_read) : r_is_wr;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_req) begin
               w_cnt_nxt   = 4'(LATENCY);
               w_state_nxt = (LATENCY == 0) ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            w_cnt_nxt = r_cnt - 4'd1;
            if (r_cnt <= 4'd1) begin
               w_state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Violations: simultaneous read+write at accept, or the held request
   // dropping or changing while the transaction is in flight. Write data is
   // only meaningful for writes, so it is compared only then.
   always_comb begin
      w_viol = 1'b0;
      if (w_accept && mem_read && mem_write) begin
         w_viol = 1'b1;
      end
      if ((r_state == S_WAIT) || (r_state == S_RESP)) begin
         if (!w_req ||
             (mem_address != r_addr) ||
             ({mem_read, mem_write} != r_op) ||
             (r_is_wr && (mem_wdata != r_wdata))) begin
            w_viol = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_resp  <= 1'b0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_resp  <= (w_state_nxt == S_RESP);
         if ((w_state_nxt == S_RESP) && !w_is_wr_nxt) begin
            r_rdata <= r_mem[w_rd_idx];
         end
         if (w_viol) begin
            r_err <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_idx   <= w_req_idx;
         r_addr  <= mem_address;
         r_wdata <= mem_wdata;
         r_be    <= mem_byte_enable;
         r_op    <= {mem_read, mem_write};
         r_is_wr <= mem_write & ~mem_read;
      end
   end

   // Commit at the end of the response cycle; a reset in that cycle abandons it.
   always_ff @(posedge clk) begin
      if (!rst && (r_state == S_RESP) && r_is_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (r_be[i]) begin
               r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
            end
         end
      end
   end

   assign mem_resp  = r_resp;
   assign mem_rdata = r_rdata;
   assign proto_err = r_err;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   always #5 clk = ~clk;

   // Instance A: LATENCY=3, instance B: LATENCY=0
   logic        a_rd, a_wr, a_resp, a_err;
   logic [3:0]  a_be;
   logic [31:0] a_addr, a_wdata, a_rdata;
   logic        b_rd, b_wr, b_resp, b_err;
   logic [3:0]  b_be;
   logic [31:0] b_addr, b_wdata, b_rdata;

   mem_responder #(.ADDR_BITS(8), .LATENCY(3)) u_dut_a (
      .clk(clk), .rst(rst), .mem_read(a_rd), .mem_write(a_wr),
      .mem_byte_enable(a_be), .mem_address(a_addr), .mem_wdata(a_wdata),
      .mem_resp(a_resp), .mem_rdata(a_rdata), .proto_err(a_err));

   mem_responder #(.ADDR_BITS(8), .LATENCY(0)) u_dut_b (
      .clk(clk), .rst(rst), .mem_read(b_rd), .mem_write(b_wr),
      .mem_byte_enable(b_be), .mem_address(b_addr), .mem_wdata(b_wdata),
      .mem_resp(b_resp), .mem_rdata(b_rdata), .proto_err(b_err));

   int n_cmp = 0;
   int n_bad = 0;
   int a_pulses = 0;
   int b_pulses = 0;

   // Reference model for instance A
   logic [31:0] ref_mem [256];
   logic [31:0] ref_last_rd = '0;
   logic        ref_err = 1'b0;
   logic [31:0] b_ref [10];

   always @(negedge clk) begin
      if (a_resp) a_pulses++;
      if (b_resp) b_pulses++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Spec-level behaviour: returns what mem_rdata shows in the response cycle.
   function automatic logic [31:0] model(input logic rd, input logic wr,
                                         input logic [31:0] ad, input logic [31:0] d,
                                         input logic [3:0] be);
      logic [7:0] idx;
      idx = ad[9:2];
      if (rd) begin
         if (wr) ref_err = 1'b1;
         ref_last_rd = ref_mem[idx];
      end else if (wr) begin
         for (int i = 0; i < 4; i++)
            if (be[i]) ref_mem[idx][8*i +: 8] = d[8*i +: 8];
      end
      return ref_last_rd;
   endfunction

   // Called at posedge+1; returns the cycle index (0 = request cycle) of mem_resp.
   task automatic txn_a(input logic rd, input logic wr, input logic [31:0] ad,
                        input logic [31:0] d, input logic [3:0] be,
                        input bit glitch, input logic [31:0] ad2,
                        output logic [31:0] rdata, output int lat);
      a_rd = rd; a_wr = wr; a_addr = ad; a_wdata = d; a_be = be;
      lat = -1; rdata = '0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (a_resp) begin
            lat = k; rdata = a_rdata;
            break;
         end
         if (glitch && k == 0) begin
            @(posedge clk); #1;
            a_addr = ad2;
         end
      end
      @(posedge clk); #1;
      a_rd = 1'b0; a_wr = 1'b0;
   endtask

   task automatic run_a(input string nm, input logic rd, input logic wr,
                        input logic [31:0] ad, input logic [31:0] d, input logic [3:0] be,
                        input bit glitch, input logic [31:0] ad2, output logic [31:0] got);
      logic [31:0] exp;
      int lat;
      exp = model(rd, wr, ad, d, be);
      txn_a(rd, wr, ad, d, be, glitch, ad2, got, lat);
      check({nm, "_lat"}, 32'(lat), 32'd4);
      check({nm, "_rdata"}, got, exp);
   endtask

   task automatic txn_b(input logic rd, input logic wr, input logic [31:0] ad,
                        input logic [31:0] d, output logic [31:0] rdata, output int lat);
      b_rd = rd; b_wr = wr; b_addr = ad; b_wdata = d; b_be = 4'hF;
      lat = -1; rdata = '0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (b_resp) begin
            lat = k; rdata = b_rdata;
            break;
         end
      end
      @(posedge clk); #1;
      b_rd = 1'b0; b_wr = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      a_rd = 1'b0; a_wr = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      ref_last_rd = '0;
      ref_err = 1'b0;
   endtask

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[11];

   initial begin
      logic [31:0] got;
      int          lat;
      int          p0;
      longint      t0;

      tbl[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 32'h0000_0000};
      tbl[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,        4'h0, 32'hDEADBEEF};
      tbl[2]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h11223344, 4'hF, 32'hDEADBEEF};
      tbl[3]  = '{1'b0, 1'b1, 32'h0000_0020, 32'hAABBCCDD, 4'h5, 32'hDEADBEEF};
      tbl[4]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,        4'hF, 32'h11BB33DD};
      tbl[5]  = '{1'b0, 1'b1, 32'h0000_0020, 32'hFFFFFFFF, 4'h0, 32'h11BB33DD};
      tbl[6]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,        4'h0, 32'h11BB33DD};
      tbl[7]  = '{1'b0, 1'b1, 32'h0000_0400, 32'h5A5A5A5A, 4'hF, 32'h11BB33DD};
      tbl[8]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,        4'h0, 32'h5A5A5A5A};
      tbl[9]  = '{1'b1, 1'b0, 32'h0000_0003, 32'h0,        4'h0, 32'h5A5A5A5A};
      tbl[10] = '{1'b1, 1'b0, 32'hFFFF_FC12, 32'h0,        4'h0, 32'hDEADBEEF};

      rst = 1'b1;
      a_rd = 0; a_wr = 0; a_be = 0; a_addr = 0; a_wdata = 0;
      b_rd = 0; b_wr = 0; b_be = 0; b_addr = 0; b_wdata = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      check("rst_a_resp", {31'b0, a_resp}, 32'd0);
      check("rst_a_rdata", a_rdata, 32'd0);
      check("rst_a_err", {31'b0, a_err}, 32'd0);
      check("rst_b_resp", {31'b0, b_resp}, 32'd0);
      check("rst_b_rdata", b_rdata, 32'd0);
      check("rst_b_err", {31'b0, b_err}, 32'd0);
      @(posedge clk); #1;

      // Fill every word so later reads are always defined
      for (int i = 0; i < 256; i++)
         run_a("init", 1'b0, 1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0, 32'h0, got);

      for (int i = 0; i < 11; i++) begin
         run_a($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].addr,
               tbl[i].wdata, tbl[i].be, 1'b0, 32'h0, got);
         check($sformatf("vec%0d_const", i), got, tbl[i].exp);
      end
      check("vec_err_clear", {31'b0, a_err}, 32'd0);

      p0 = a_pulses;
      for (int i = 0; i < 150; i++) begin
         logic op;
         op = 1'($urandom_range(0, 1));
         run_a("rand", op, ~op, $urandom, $urandom, 4'($urandom), 1'b0, 32'h0, got);
      end
      check("rand_pulse_count", 32'(a_pulses - p0), 32'd150);
      check("rand_err_clear", {31'b0, a_err}, 32'd0);

      // Read and write together: served as a read, no write, flag raised
      run_a("both", 1'b1, 1'b1, 32'h10, 32'h12345678, 4'hF, 1'b0, 32'h0, got);
      check("both_err", {31'b0, a_err}, {31'b0, ref_err});
      run_a("both_after", 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'h0, got);
      check("both_err_sticky", {31'b0, a_err}, 32'd1);

      do_reset();
      @(negedge clk);
      check("rst2_err", {31'b0, a_err}, 32'd0);
      @(posedge clk); #1;

      // Address moved during WAIT: response uses the original address
      run_a("pre80", 1'b0, 1'b1, 32'h80, 32'h0BADF00D, 4'hF, 1'b0, 32'h0, got);
      run_a("pre84", 1'b0, 1'b1, 32'h84, 32'h600DCAFE, 4'hF, 1'b0, 32'h0, got);
      check("glitch_err_pre", {31'b0, a_err}, 32'd0);
      run_a("glitch_rd", 1'b1, 1'b0, 32'h80, 32'h0, 4'h0, 1'b1, 32'h84, got);
      check("glitch_rd_const", got, 32'h0BADF00D);
      check("glitch_rd_err", {31'b0, a_err}, 32'd1);
      run_a("glitch_wr", 1'b0, 1'b1, 32'h88, 32'h77777777, 4'hF, 1'b1, 32'h8C, got);
      run_a("glitch_wr_rd88", 1'b1, 1'b0, 32'h88, 32'h0, 4'h0, 1'b0, 32'h0, got);
      check("glitch_wr_rd88_const", got, 32'h77777777);
      run_a("glitch_wr_rd8c", 1'b1, 1'b0, 32'h8C, 32'h0, 4'h0, 1'b0, 32'h0, got);
      check("glitch_err_sticky", {31'b0, a_err}, 32'd1);

      // Reset during WAIT of a write abandons it
      run_a("t6_zero", 1'b0, 1'b1, 32'h40, 32'h0, 4'hF, 1'b0, 32'h0, got);
      p0 = a_pulses;
      a_wr = 1'b1; a_addr = 32'h40; a_wdata = 32'hCAFEF00D; a_be = 4'hF;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; a_wr = 1'b0;
      ref_last_rd = '0; ref_err = 1'b0;
      repeat (6) @(negedge clk);
      check("t6_no_resp", 32'(a_pulses - p0), 32'd0);
      check("t6_rdata", a_rdata, 32'd0);
      check("t6_err", {31'b0, a_err}, 32'd0);
      @(posedge clk); #1;
      run_a("t6_read", 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 32'h0, got);
      check("t6_read_const", got, 32'h0);

      // LATENCY=0 instance: single-cycle wait and back-to-back throughput
      for (int i = 0; i < 10; i++) begin
         b_ref[i] = $urandom;
         txn_b(1'b0, 1'b1, 32'(i * 4), b_ref[i], got, lat);
         check($sformatf("b_wr%0d_lat", i), 32'(lat), 32'd1);
      end
      p0 = b_pulses;
      t0 = $time;
      for (int i = 0; i < 10; i++) begin
         txn_b(1'b1, 1'b0, 32'(i * 4), 32'h0, got, lat);
         check($sformatf("b_rd%0d_lat", i), 32'(lat), 32'd1);
         check($sformatf("b_rd%0d_rdata", i), got, b_ref[i]);
      end
      check("b_b2b_cycles", 32'(($time - t0) / 10), 32'd20);
      check("b_b2b_pulses", 32'(b_pulses - p0), 32'd10);
      check("b_err", {31'b0, b_err}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
